quad_decoder: RTL and testbench
===============================

// Module: quad_decoder
// PURPOSE
//  Quadrature decoder stage consuming the debounced A/B channels of a rotary encoder.
//  Tracks Gray-code phase (00->01->11->10->00) and maintains an up/down value register.
//  Output value feeds the PWM duty input of one colour channel of the RGB mixer.
//  Emits a one-cycle step pulse with direction, and a one-cycle error pulse on illegal transitions.
// PARAMETERS
//  WIDTH      8     width of value register
//  STEP       1     amount added/subtracted per valid phase transition (1..2^WIDTH-1)
//  SATURATE   1     1 = clamp at 0 / 2^WIDTH-1; 0 = modular wrap-around
//  INIT_VALUE 0     value loaded on reset and on clear
// PORTS
//  clk        in   1      system clock, all logic on rising edge
//  reset      in   1      asynchronous, active-low reset
//  clear      in   1      synchronous clear of value to INIT_VALUE
//  enc_a      in   1      debounced channel A, synchronous to clk
//  enc_b      in   1      debounced channel B, synchronous to clk
//  value      out  WIDTH  current count (registered)
//  step       out  1      1-cycle pulse on every valid transition (even if clamped)
//  dir        out  1      direction of last valid transition: 1 = up (CW), 0 = down; holds between steps
//  err        out  1      1-cycle pulse when both channels change in one cycle
// BEHAVIOUR
//  Reset (reset=0, asynchronous): value=INIT_VALUE, step=0, dir=0, err=0, prev_ab=00, primed=0.
//  States: UNPRIMED (primed=0), TRACKING (primed=1).
//   UNPRIMED: first clock edge after reset release loads prev_ab<={enc_a,enc_b}, primed<=1;
//     no count, step=0, err=0 (no spurious count from unknown start phase).
//   TRACKING: each edge compare cur={enc_a,enc_b} with prev_ab, then prev_ab<=cur.
//  Transition table (prev->cur):
//   00->01, 01->11, 11->10, 10->00 : up; value+=STEP, step=1, dir=1.
//   00->10, 10->11, 11->01, 01->00 : down; value-=STEP, step=1, dir=0.
//   cur==prev                      : no change, step=0, err=0.
//   both bits differ (00<->11, 01<->10): err=1, step=0, value and dir unchanged; prev_ab still updated.
//  Latency: input change sampled at edge N -> value/step/dir/err valid after edge N (one register stage).
//  step and err are mutually exclusive; each is high for exactly one cycle per event.
//  Arithmetic in WIDTH+1 bits before clamp/wrap:
//   SATURATE=1: up result > 2^WIDTH-1 -> 2^WIDTH-1; down result < 0 -> 0. step still pulses, dir still updates.
//   SATURATE=0: result taken modulo 2^WIDTH (e.g. WIDTH=8: 255+1 -> 0, 0-1 -> 255).
//  clear=1: value<=INIT_VALUE; step=0, err=0 that cycle; prev_ab still tracks inputs;
//   a transition coincident with clear is discarded (clear wins). primed unaffected.
//  Reset asserted mid-operation: all state returns to reset values immediately; decoder re-primes
//   on first edge after release.
//  Inputs assumed already synchronous and debounced; no internal synchroniser.
// TESTING
//  Reset release with enc_a=1,enc_b=1 held -> value stays 0, step never pulses; then 11->10 -> value=1, step=1 cycle, dir=1.
//  Full CW cycle 00->01->11->10->00 from value=0 (STEP=1) -> value=4, four step pulses, dir=1; reverse cycle -> value=0, dir=0.
//  SATURATE=1, value=254, three CW transitions -> 255,255,255, three step pulses; SATURATE=0 same -> 255,0,1.
//  Illegal 00->11 in one cycle -> err=1 for one cycle, step=0, value unchanged; next 11->10 counts up normally.
//  clear asserted on same cycle as valid CW transition from value=10 -> value=INIT_VALUE, step=0; next transition counts from INIT_VALUE.
//  reset pulsed low between clock edges while value=37 -> value=0 immediately (async), outputs 0, re-prime on first edge.

Source files
------------

// File: rtl/quad_decoder.sv
// -----------------------------------------------------------------------------
// quad_decoder
//   Quadrature decoder for the debounced A/B channels of a rotary encoder.
//   It follows the Gray-code phase sequence 00->01->11->10->00 and keeps an
//   up/down value register, which drives a PWM duty input downstream. Each
//   valid phase transition produces a one-cycle step pulse together with the
//   direction. A transition where both channels change in the same cycle
//   produces a one-cycle err pulse instead.
//
// Parameters
//   WIDTH      width of the value register
//   STEP       amount added/subtracted per valid transition (1..2^WIDTH-1)
//   SATURATE   1 = clamp at 0 / 2^WIDTH-1, 0 = modular wrap-around
//   INIT_VALUE value loaded on reset and on clear
//
// Ports
//   clk    in   system clock, rising edge
//   reset  in   asynchronous active-low reset
//   clear  in   synchronous clear of value to INIT_VALUE (wins over a step)
//   enc_a  in   channel A, already synchronous and debounced
//   enc_b  in   channel B, already synchronous and debounced
//   value  out  current count (registered)
//   step   out  one-cycle pulse per valid transition (also when clamped)
//   dir    out  direction of the last valid transition, 1 = up (CW)
//   err    out  one-cycle pulse when both channels change at once
// -----------------------------------------------------------------------------
module quad_decoder #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned STEP       = 1,
  parameter bit          SATURATE   = 1'b1,
  parameter int unsigned INIT_VALUE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enc_a,
  input  logic             enc_b,
  output logic [WIDTH-1:0] value,
  output logic             step,
  output logic             dir,
  output logic             err
);

  typedef enum logic {
    UNPRIMED,
    TRACKING
  } state_e;

  localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT_VALUE);

  state_e           state_q, state_d;
  logic [1:0]       prev_ab_q, prev_ab_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             step_q, step_d;
  logic             dir_q, dir_d;
  logic             err_q, err_d;

  logic [1:0]       cur_ab;
  logic             is_up, is_down, is_err;
  logic [WIDTH:0]   sum_x, diff_x;
  logic [WIDTH-1:0] up_val, down_val;

  // Phase transition classification
  always_comb begin
    cur_ab  = {enc_a, enc_b};
    is_up   = 1'b0;
    is_down = 1'b0;
    unique case ({prev_ab_q, cur_ab})
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: is_up   = 1'b1;
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: is_down = 1'b1;
      default: ;
    endcase
    is_err = (prev_ab_q ^ cur_ab) == 2'b11;
  end

  // Arithmetic in WIDTH+1 bits: bit WIDTH is carry on up, borrow on down
  always_comb begin
    sum_x    = {1'b0, value_q} + STEP_X;
    diff_x   = {1'b0, value_q} - STEP_X;
    up_val   = (SATURATE && sum_x[WIDTH])  ? '1 : sum_x[WIDTH-1:0];
    down_val = (SATURATE && diff_x[WIDTH]) ? '0 : diff_x[WIDTH-1:0];
  end

  always_comb begin
    state_d   = state_q;
    prev_ab_d = cur_ab;
    value_d   = value_q;
    step_d    = 1'b0;
    dir_d     = dir_q;
    err_d     = 1'b0;

    if (state_q == UNPRIMED) begin
      state_d = TRACKING;
    end

    if (clear) begin
      value_d = INIT_V;
    end else if (state_q == TRACKING) begin
      if (is_up) begin
        value_d = up_val;
        step_d  = 1'b1;
        dir_d   = 1'b1;
      end else if (is_down) begin
        value_d = down_val;
        step_d  = 1'b1;
        dir_d   = 1'b0;
      end else if (is_err) begin
        err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= UNPRIMED;
      prev_ab_q <= '0;
      value_q   <= INIT_V;
      step_q    <= 1'b0;
      dir_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_ab_q <= prev_ab_d;
      value_q   <= value_d;
      step_q    <= step_d;
      dir_q     <= dir_d;
      err_q     <= err_d;
    end
  end

  assign value = value_q;
  assign step  = step_q;
  assign dir   = dir_q;
  assign err   = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// -----------------------------------------------------------------------------
// tb_quad_decoder
//   Four decoder instances with different WIDTH/STEP/SATURATE/INIT_VALUE share
//   one stimulus stream. The stimulus process updates a phase-index reference
//   model and pushes the expected outputs for the next edge into a queue. The
//   monitor pops one entry per edge and compares it against all instances.
// -----------------------------------------------------------------------------
module tb_quad_decoder;

  localparam int NI = 4;
  localparam int Ws  [NI] = '{8, 8, 4, 4};
  localparam int Ss  [NI] = '{1, 1, 5, 5};
  localparam int SATs[NI] = '{1, 0, 1, 0};
  localparam int INIs[NI] = '{0, 0, 3, 3};
  localparam logic [1:0] GRAY [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  logic clk = 1'b0;
  logic reset, clear, enc_a, enc_b;
  logic [7:0] v0, v1;
  logic [3:0] v2, v3;
  logic [NI-1:0] st, dr, er;

  always #5 clk = ~clk;

  quad_decoder #(.WIDTH(8), .STEP(1), .SATURATE(1'b1), .INIT_VALUE(0)) u0 (
    .clk(clk), .reset(reset), .clear(clear), .enc_a(enc_a), .enc_b(enc_b),
    .value(v0), .step(st[0]), .dir(dr[0]), .err(er[0]));
  quad_decoder #(.WIDTH(8), .STEP(1), .SATURATE(1'b0), .INIT_VALUE(0)) u1 (
    .clk(clk), .reset(reset), .clear(clear), .enc_a(enc_a), .enc_b(enc_b),
    .value(v1), .step(st[1]), .dir(dr[1]), .err(er[1]));
  quad_decoder #(.WIDTH(4), .STEP(5), .SATURATE(1'b1), .INIT_VALUE(3)) u2 (
    .clk(clk), .reset(reset), .clear(clear), .enc_a(enc_a), .enc_b(enc_b),
    .value(v2), .step(st[2]), .dir(dr[2]), .err(er[2]));
  quad_decoder #(.WIDTH(4), .STEP(5), .SATURATE(1'b0), .INIT_VALUE(3)) u3 (
    .clk(clk), .reset(reset), .clear(clear), .enc_a(enc_a), .enc_b(enc_b),
    .value(v3), .step(st[3]), .dir(dr[3]), .err(er[3]));

  typedef struct packed {
    logic [NI-1:0][7:0] val;
    logic               step;
    logic               dir;
    logic               err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state
  int         m_val[NI];
  bit         m_primed;
  logic [1:0] m_prev;
  bit         m_dir;
  int         ph;

  function automatic int phase_of(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int next_val(input int v, input bit up, input int i);
    int maxv = (1 << Ws[i]) - 1;
    int r    = up ? v + Ss[i] : v - Ss[i];
    if (SATs[i] != 0) begin
      if (r > maxv) r = maxv;
      if (r < 0)    r = 0;
    end else begin
      if (r > maxv) r = r - (maxv + 1);
      if (r < 0)    r = r + (maxv + 1);
    end
    return r;
  endfunction

  function automatic logic [NI-1:0][7:0] pack_vals();
    logic [NI-1:0][7:0] p;
    for (int i = 0; i < NI; i++) p[i] = 8'(m_val[i]);
    return p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) m_val[i] = INIs[i];
    m_primed = 1'b0;
    m_prev   = 2'b00;
    m_dir    = 1'b0;
  endtask

  // One clock of stimulus; reset is released here so the model and DUT
  // always see the same first edge.
  task automatic cyc(input logic a, input logic b, input logic clr);
    exp_t e;
    int   d;
    @(negedge clk);
    reset = 1'b1;
    enc_a = a;
    enc_b = b;
    clear = clr;
    e.step = 1'b0;
    e.err  = 1'b0;
    d = (phase_of({a, b}) - phase_of(m_prev) + 4) % 4;
    if (clr) begin
      for (int i = 0; i < NI; i++) m_val[i] = INIs[i];
    end else if (m_primed) begin
      if (d == 1 || d == 3) begin
        for (int i = 0; i < NI; i++) m_val[i] = next_val(m_val[i], d == 1, i);
        m_dir  = (d == 1);
        e.step = 1'b1;
      end else if (d == 2) begin
        e.err = 1'b1;
      end
    end
    m_primed = 1'b1;
    m_prev   = {a, b};
    e.val    = pack_vals();
    e.dir    = m_dir;
    exp_q.push_back(e);
  endtask

  task automatic move(input bit cw, input logic clr);
    ph = cw ? (ph + 1) % 4 : (ph + 3) % 4;
    cyc(GRAY[ph][1], GRAY[ph][0], clr);
  endtask

  task automatic check_reset_state(input string name);
    logic [NI-1:0][7:0] act;
    act = {{4'b0, v3}, {4'b0, v2}, v1, v0};
    n_checks++;
    if (act != pack_vals() || st != '0 || dr != '0 || er != '0) begin
      n_fail++;
      $display("FAIL %s: value=%h step=%b dir=%b err=%b required value=%h step=0 dir=0 err=0",
               name, act, st, dr, er, pack_vals());
    end
  endtask

  // Async reset between edges, checked before any further edge
  task automatic async_reset();
    @(posedge clk);
    #3 reset = 1'b0;
    model_reset();
    #1 check_reset_state("async_reset");
  endtask

  // Monitor: one expected entry per edge while stimulus is active
  initial begin
    exp_t               e;
    logic [NI-1:0][7:0] act;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        act = {{4'b0, v3}, {4'b0, v2}, v1, v0};
        for (int i = 0; i < NI; i++) begin
          n_checks++;
          if (act[i] != e.val[i] || st[i] != e.step || dr[i] != e.dir || er[i] != e.err) begin
            n_fail++;
            $display("FAIL inst%0d @%0t: value=%0d step=%b dir=%b err=%b required value=%0d step=%b dir=%b err=%b",
                     i, $time, act[i], st[i], dr[i], er[i], e.val[i], e.step, e.dir, e.err);
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    clear = 1'b0;
    enc_a = 1'b1;
    enc_b = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_state("reset_state");

    // Release with 11 held: priming must not count
    repeat (3) cyc(1'b1, 1'b1, 1'b0);
    ph = 2;
    move(1'b1, 1'b0);                 // 11->10 up
    move(1'b1, 1'b0);                 // 10->00 up
    repeat (4) move(1'b1, 1'b0);      // full CW cycle
    repeat (4) move(1'b0, 1'b0);      // full CCW cycle

    // Illegal 00->11, then normal count
    cyc(1'b1, 1'b1, 1'b0);
    ph = 2;
    move(1'b1, 1'b0);

    // Clear coincident with a transition, then count from INIT_VALUE
    repeat (8) move(1'b1, 1'b0);
    move(1'b1, 1'b1);
    move(1'b1, 1'b0);

    // Drive through both ends of every range
    repeat (300) move(1'b1, 1'b0);
    repeat (300) move(1'b0, 1'b0);
    repeat (37) move(1'b1, 1'b0);

    async_reset();
    cyc(enc_a, enc_b, 1'b0);          // re-prime
    ph = phase_of({enc_a, enc_b});
    move(1'b1, 1'b0);

    // Randomised phase changes, illegal jumps, clears and resets
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(199) == 0) begin
        async_reset();
      end
      cyc(1'($urandom_range(1)), 1'($urandom_range(1)), ($urandom_range(15) == 0));
    end

    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: pending=%0d required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
